// File: rtl/pad_hdx_pkg.sv
// Shared types and frame constants for the half-duplex pad link controller.
package pad_hdx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TURN,
        RX_START,
        RX_DATA,
        RX_STOP
    } state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/pad_hdx_sync.sv
// Two-flop synchroniser for the pad Y input; resets to the idle (high) level.
module pad_hdx_sync (
    input  logic clk,
    input  logic rn,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) ff <= 2'b11;
        else     ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/pad_hdx_link_ctrl.sv
// Half-duplex single-wire byte link controller for one tristate pad cell.
// Owns pad direction, the post-TX turnaround guard and the termination pulls.
module pad_hdx_link_ctrl
    import pad_hdx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int GUARD_BITS   = 2,
    parameter bit PD_IDLE      = 1'b0
) (
    input  logic       clk,
    input  logic       rn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic       pad_a,
    output logic       pad_en,
    output logic       pad_puen,
    output logic       pad_pden,
    input  logic       pad_y
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = (GUARD_BITS > DATA_BITS) ? $clog2(GUARD_BITS) : $clog2(DATA_BITS);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] MID  = TW'(CLKS_PER_BIT / 2 - 1);

    state_t          state, state_nx;
    logic [TW-1:0]   tmr, tmr_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic [7:0]      txsh, txsh_nx, rxsh, rxsh_nx, rx_data_nx;
    logic            rx_valid_nx, frame_err_nx;
    logic            live, y_s, y_q, fell, bit_end, mid;

    pad_hdx_sync u_sync (.clk(clk), .rn(rn), .d(pad_y), .q(y_s));

    assign fell    = y_q & ~y_s;
    assign bit_end = (tmr == LAST);
    assign mid     = (tmr == MID);

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state     <= IDLE;
            tmr       <= '0;
            idx       <= '0;
            txsh      <= '0;
            rxsh      <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            live      <= 1'b0;
            y_q       <= 1'b1;
        end else begin
            state     <= state_nx;
            tmr       <= tmr_nx;
            idx       <= idx_nx;
            txsh      <= txsh_nx;
            rxsh      <= rxsh_nx;
            rx_data   <= rx_data_nx;
            rx_valid  <= rx_valid_nx;
            frame_err <= frame_err_nx;
            live      <= 1'b1;
            y_q       <= y_s;
        end
    end

    always_comb begin
        state_nx     = state;
        tmr_nx       = bit_end ? '0 : tmr + 1'b1;
        idx_nx       = idx;
        txsh_nx      = txsh;
        rxsh_nx      = rxsh;
        rx_data_nx   = rx_data;
        rx_valid_nx  = 1'b0;
        frame_err_nx = 1'b0;
        tx_ready     = live && (state == IDLE) && !fell;
        case (state)
            IDLE: begin
                tmr_nx = '0;
                idx_nx = '0;
                // The edge-detect cycle is tick 0 of the start bit, so RX starts at 1.
                if (fell) begin
                    state_nx = RX_START;
                    tmr_nx   = TW'(1);
                end else if (tx_valid && tx_ready) begin
                    state_nx = TX_START;
                    txsh_nx  = tx_data;
                end
            end
            TX_START: if (bit_end) state_nx = TX_DATA;
            TX_DATA: if (bit_end) begin
                txsh_nx = txsh >> 1;
                idx_nx  = idx + 1'b1;
                if (idx == IW'(DATA_BITS - 1)) begin
                    state_nx = TX_STOP;
                    idx_nx   = '0;
                end
            end
            TX_STOP: if (bit_end) state_nx = TURN;
            TURN: if (bit_end) begin
                idx_nx = idx + 1'b1;
                if (idx == IW'(GUARD_BITS - 1)) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end
            end
            RX_START: begin
                if (mid && (y_s != START_LVL)) state_nx = IDLE;
                else if (bit_end)              state_nx = RX_DATA;
            end
            RX_DATA: begin
                if (mid) rxsh_nx = {y_s, rxsh[7:1]};
                if (bit_end) begin
                    idx_nx = idx + 1'b1;
                    if (idx == IW'(DATA_BITS - 1)) begin
                        state_nx = RX_STOP;
                        idx_nx   = '0;
                    end
                end
            end
            RX_STOP: if (mid) begin
                state_nx = IDLE;
                if (y_s == STOP_LVL) begin
                    rx_valid_nx = 1'b1;
                    rx_data_nx  = rxsh;
                end else begin
                    frame_err_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pad outputs decode straight from state so reset releases the pad without a clock.
    always_comb begin
        pad_en = 1'b1;
        pad_a  = STOP_LVL;
        case (state)
            TX_START: begin pad_en = 1'b0; pad_a = START_LVL; end
            TX_DATA:  begin pad_en = 1'b0; pad_a = txsh[0];   end
            TX_STOP:  begin pad_en = 1'b0; pad_a = STOP_LVL;  end
            default:  ;
        endcase
    end

    assign pad_puen = pad_en ? PD_IDLE  : 1'b1;
    assign pad_pden = pad_en ? !PD_IDLE : 1'b1;
    assign busy     = (state != IDLE);

endmodule
